// File: rtl/data_mem_arb_pkg.sv
// data_mem_arb_pkg: shared FSM states, port count, default timeout and sign_mask field positions.
package data_mem_arb_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  localparam int NPORT = 2;
  localparam int TIMEOUT_DEF = 16;
  localparam int MASK_SIGN = 3;
  localparam int MASK_WORD = 2;
  localparam int MASK_HALF = 1;
  localparam int MASK_W = 4;
endpackage

// File: rtl/data_mem_arb_pick.sv
// data_mem_arb_pick: combinational two-port winner select; a tie goes to the port not granted last.
module data_mem_arb_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);
  assign grant = (&req) ? (last ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/data_mem_arb.sv
// data_mem_arb: two-port data-memory arbiter, one transaction at a time, with stall timeout.
// Define DATA_MEM_ARB_RR_EN for round-robin ties; otherwise port 0 always wins ties.
module data_mem_arb #(
  parameter int TIMEOUT_CYCLES = data_mem_arb_pkg::TIMEOUT_DEF,
  parameter int NPORT = data_mem_arb_pkg::NPORT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NPORT-1:0]     p_req,
  input  logic [NPORT-1:0]     p_we,
  input  logic [32*NPORT-1:0]  p_addr,
  input  logic [32*NPORT-1:0]  p_wdata,
  input  logic [4*NPORT-1:0]   p_mask,
  output logic [NPORT-1:0]     p_ack,
  output logic [31:0]          rdata,
  output logic                 err,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  output logic [data_mem_arb_pkg::MASK_W-1:0] mem_mask,
  output logic                 mem_read,
  output logic                 mem_write,
  input  logic [31:0]          mem_rdata,
  input  logic                 mem_stall
);
  import data_mem_arb_pkg::*;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [1:0] r_gnt, w_grant;
  logic r_we, r_err, w_last, w_take, w_done, w_tmo;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [MASK_W-1:0] r_mask;
`ifdef DATA_MEM_ARB_RR_EN
  logic r_last;
  assign w_last = r_last;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_last <= 1'b1;
    else if (w_take) r_last <= w_grant[1];
`else
  assign w_last = 1'b1;
`endif
  data_mem_arb_pick u_pick (.req(p_req), .last(w_last), .grant(w_grant));
  assign w_take = r_state == S_IDLE && |p_req;
  // the first WAIT cycle never exits, so mem_stall is only looked at once r_cnt >= 1
  assign w_done = r_state == S_WAIT && r_cnt != '0 && !mem_stall;
  assign w_tmo  = r_state == S_WAIT && r_cnt == CW'(TIMEOUT_CYCLES) && mem_stall;
  assign rdata = r_rdata;
  assign mem_addr = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_mask = r_mask;
  always_comb begin
    w_next = r_state;
    p_ack = '0;
    err = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    case (r_state)
      S_IDLE:  w_next = w_take ? S_ISSUE : S_IDLE;
      S_ISSUE: begin
        w_next = S_WAIT;
        mem_read = !r_we;
        mem_write = r_we;
      end
      S_WAIT:  w_next = (w_done || w_tmo) ? S_RESP : S_WAIT;
      default: begin
        w_next = S_IDLE;
        p_ack = r_gnt;
        err = r_err;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt <= '0;
      r_gnt <= '0;
      r_we <= 1'b0;
      r_err <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
      r_mask <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= (r_state == S_WAIT && w_next == S_WAIT) ? r_cnt + CW'(1) : '0;
      if (w_take) begin
        r_gnt <= w_grant;
        r_we <= w_grant[1] ? p_we[1] : p_we[0];
        r_addr <= w_grant[1] ? p_addr[32 +: 32] : p_addr[0 +: 32];
        r_wdata <= w_grant[1] ? p_wdata[32 +: 32] : p_wdata[0 +: 32];
        r_mask <= w_grant[1] ? p_mask[MASK_W +: MASK_W] : p_mask[0 +: MASK_W];
      end
      if (w_done) begin
        r_rdata <= mem_rdata;
        r_err <= 1'b0;
      end
      if (w_tmo) begin
        r_rdata <= '0;
        r_err <= 1'b1;
      end
    end
endmodule

// File: tb/tb_data_mem_arb.sv
// tb_data_mem_arb: randomized self-checking bench for data_mem_arb against a latency/arbitration model.
module tb_data_mem_arb;
  localparam int T = 16;
`ifdef DATA_MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0;
  logic [1:0] p_req, p_we, p_ack;
  logic [63:0] p_addr, p_wdata;
  logic [7:0] p_mask;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0] mem_mask;
  logic err, mem_read, mem_write, mem_stall;
  int n_chk = 0, n_fail = 0;
  logic [31:0] a_q[2], wd_q[2];
  logic [3:0] m_q[2];
  logic we_q[2];
  int ki, lat, nrd, nwr;
  logic [1:0] ack;
  logic [31:0] rd, a, wd;
  logic [3:0] m;
  logic e, st;

  data_mem_arb #(.TIMEOUT_CYCLES(T), .NPORT(2)) dut (
    .clk(clk), .rst(rst), .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_mask(p_mask), .p_ack(p_ack), .rdata(rdata), .err(err), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_mask(mem_mask), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .mem_stall(mem_stall));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int exp_lat(input int s);
    int j;
    j = (s + 1 > 2) ? s + 1 : 2;
    return (s >= T + 1) ? T + 2 : j + 1;
  endfunction

  task automatic drive();
    p_addr = {a_q[1], a_q[0]};
    p_wdata = {wd_q[1], wd_q[0]};
    p_mask = {m_q[1], m_q[0]};
    p_we = {we_q[1], we_q[0]};
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int s, output int o_ki, output int o_lat, output logic [1:0] o_ack,
                     output logic [31:0] o_rd, output logic o_e, output int o_nrd, output int o_nwr,
                     output logic [31:0] o_a, output logic [31:0] o_wd, output logic [3:0] o_m,
                     output logic o_st);
    o_ki = -1; o_lat = -1; o_ack = '0; o_rd = '0; o_e = 1'b0; o_nrd = 0; o_nwr = 0;
    o_a = '0; o_wd = '0; o_m = '0; o_st = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk);
      #1;
      o_nrd += int'(mem_read);
      o_nwr += int'(mem_write);
      if (o_ki < 0 && (mem_read || mem_write)) begin
        o_ki = c; o_a = mem_addr; o_wd = mem_wdata; o_m = mem_mask;
      end
      if (o_ki >= 0 && {mem_addr, mem_wdata, mem_mask} !== {o_a, o_wd, o_m}) o_st = 1'b0;
      if (p_ack != 2'b00) begin
        o_lat = c - o_ki; o_ack = p_ack; o_rd = rdata; o_e = err;
        p_req = p_req & ~p_ack;
        mem_stall = 1'b0;
        break;
      end
      mem_stall = o_ki >= 0 && c - o_ki >= 1 && c - o_ki <= s;
    end
  endtask

  task automatic test_reset();
    p_req = '0; p_we = '0; p_addr = '0; p_wdata = '0; p_mask = '0;
    mem_rdata = '0; mem_stall = 1'b0;
    for (int i = 0; i < 2; i++) begin a_q[i] = '0; wd_q[i] = '0; m_q[i] = '0; we_q[i] = 1'b0; end
    #1 rst = 1'b1;
    @(negedge clk);
    n_chk++; if (p_ack !== 2'b00) begin n_fail++; $display("FAIL rst_ack got %b want 00", p_ack); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b want 0", err); end
    n_chk++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got %h want 0", rdata); end
    n_chk++; if ({mem_read, mem_write} !== 2'b00) begin n_fail++; $display("FAIL rst_strobe got %b want 00", {mem_read, mem_write}); end
    n_chk++; if ({mem_addr, mem_wdata, mem_mask} !== 68'h0) begin n_fail++; $display("FAIL rst_fields got %h want 0", {mem_addr, mem_wdata, mem_mask}); end
    rst = 1'b0;
    idle();
  endtask

  task automatic test_read();
    a_q[0] = 32'h1004; we_q[0] = 1'b0; wd_q[0] = $urandom; m_q[0] = 4'b0100;
    drive();
    mem_rdata = 32'h12345678;
    p_req = 2'b01;
    run(1, ki, lat, ack, rd, e, nrd, nwr, a, wd, m, st);
    n_chk++; if (ki !== 1) begin n_fail++; $display("FAIL rd_issue got %0d want 1", ki); end
    n_chk++; if (ki + lat !== 4) begin n_fail++; $display("FAIL rd_ack_cycle got %0d want 4", ki + lat); end
    n_chk++; if (ack !== 2'b01) begin n_fail++; $display("FAIL rd_ack got %b want 01", ack); end
    n_chk++; if (rd !== 32'h12345678) begin n_fail++; $display("FAIL rd_data got %h want 12345678", rd); end
    n_chk++; if (e !== 1'b0) begin n_fail++; $display("FAIL rd_err got %b want 0", e); end
    n_chk++; if (nrd !== 1 || nwr !== 0) begin n_fail++; $display("FAIL rd_strobes got %0d/%0d want 1/0", nrd, nwr); end
    n_chk++; if (a !== 32'h1004) begin n_fail++; $display("FAIL rd_addr got %h want 1004", a); end
    n_chk++; if (st !== 1'b1) begin n_fail++; $display("FAIL rd_stable got %b want 1", st); end
    idle();
  endtask

  task automatic test_reset_mid();
    a_q[0] = 32'h1004; we_q[0] = 1'b0; m_q[0] = 4'b1010;
    drive();
    p_req = 2'b01;
    mem_stall = 1'b1;
    idle(); idle(); idle();
    #2 rst = 1'b1;
    #1;
    n_chk++; if (p_ack !== 2'b00 || err !== 1'b0) begin n_fail++; $display("FAIL mid_ack_err got %b/%b want 00/0", p_ack, err); end
    n_chk++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL mid_rdata got %h want 0", rdata); end
    n_chk++; if ({mem_read, mem_write} !== 2'b00) begin n_fail++; $display("FAIL mid_strobe got %b want 00", {mem_read, mem_write}); end
    n_chk++; if ({mem_addr, mem_wdata, mem_mask} !== 68'h0) begin n_fail++; $display("FAIL mid_fields got %h want 0", {mem_addr, mem_wdata, mem_mask}); end
    p_req = 2'b00; mem_stall = 1'b0;
    idle();
    n_chk++; if (p_ack !== 2'b00) begin n_fail++; $display("FAIL mid_noack got %b want 00", p_ack); end
    @(negedge clk) rst = 1'b0;
    idle();
    a_q[1] = 32'h2000; we_q[1] = 1'b0;
    drive();
    mem_rdata = $urandom;
    p_req = 2'b11;
    run(0, ki, lat, ack, rd, e, nrd, nwr, a, wd, m, st);
    n_chk++; if (ack !== 2'b01) begin n_fail++; $display("FAIL mid_first got %b want 01", ack); end
    n_chk++; if (lat !== 3 || rd !== mem_rdata) begin n_fail++; $display("FAIL mid_serve got lat %0d data %h want 3 %h", lat, rd, mem_rdata); end
    idle();
    run(0, ki, lat, ack, rd, e, nrd, nwr, a, wd, m, st);
    n_chk++; if (ack !== 2'b10 || a !== 32'h2000) begin n_fail++; $display("FAIL mid_second got %b %h want 10 2000", ack, a); end
    idle();
  endtask

  task automatic test_write();
    int s;
    s = $urandom_range(0, 3);
    a_q[1] = 32'h1008; we_q[1] = 1'b1; wd_q[1] = 32'hCAFEF00D; m_q[1] = 4'b0100;
    drive();
    mem_rdata = $urandom;
    p_req = 2'b10;
    run(s, ki, lat, ack, rd, e, nrd, nwr, a, wd, m, st);
    n_chk++; if (ack !== 2'b10) begin n_fail++; $display("FAIL wr_ack got %b want 10", ack); end
    n_chk++; if (nwr !== 1 || nrd !== 0) begin n_fail++; $display("FAIL wr_strobes got %0d/%0d want 1/0", nwr, nrd); end
    n_chk++; if (wd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL wr_wdata got %h want cafef00d", wd); end
    n_chk++; if (a !== 32'h1008 || m !== 4'b0100) begin n_fail++; $display("FAIL wr_addr_mask got %h %b want 1008 0100", a, m); end
    n_chk++; if (lat !== exp_lat(s) || e !== 1'b0) begin n_fail++; $display("FAIL wr_lat_err got %0d %b want %0d 0", lat, e, exp_lat(s)); end
    n_chk++; if (st !== 1'b1) begin n_fail++; $display("FAIL wr_stable got %b want 1", st); end
    idle();
  endtask

  task automatic test_arb();
    logic [1:0] want;
    for (int i = 0; i < 2; i++) begin a_q[i] = $urandom; we_q[i] = 1'b0; end
    drive();
    p_req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      mem_rdata = $urandom;
      want = (RR && k % 2 == 1) ? 2'b10 : 2'b01;
      run(0, ki, lat, ack, rd, e, nrd, nwr, a, wd, m, st);
      n_chk++; if (ack !== want) begin n_fail++; $display("FAIL arb_grant%0d got %b want %b", k, ack, want); end
      n_chk++; if (a !== a_q[want[1]]) begin n_fail++; $display("FAIL arb_addr%0d got %h want %h", k, a, a_q[want[1]]); end
      idle();
      p_req = 2'b11;
    end
    p_req = 2'b00;
    idle(); idle(); idle(); idle();
  endtask

  task automatic test_timeout();
    a_q[0] = $urandom; we_q[0] = 1'b0; m_q[0] = 4'b0010;
    drive();
    mem_rdata = 32'hDEADBEEF;
    p_req = 2'b01;
    run(1000, ki, lat, ack, rd, e, nrd, nwr, a, wd, m, st);
    n_chk++; if (lat !== T + 2) begin n_fail++; $display("FAIL tmo_lat got %0d want %0d", lat, T + 2); end
    n_chk++; if (ack !== 2'b01 || e !== 1'b1) begin n_fail++; $display("FAIL tmo_ack_err got %b %b want 01 1", ack, e); end
    n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL tmo_rdata got %h want 0", rd); end
    n_chk++; if (st !== 1'b1) begin n_fail++; $display("FAIL tmo_stable got %b want 1", st); end
    idle();
    n_chk++; if (err !== 1'b0 || p_ack !== 2'b00) begin n_fail++; $display("FAIL tmo_pulse got %b %b want 0 00", err, p_ack); end
  endtask

  task automatic test_random();
    logic [1:0] pend;
    logic [31:0] rdv;
    int s, w, last_m;
    logic tmo;
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    idle();
    pend = 2'b00;
    last_m = 1;
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          we_q[i] = 1'($urandom); a_q[i] = $urandom; wd_q[i] = $urandom; m_q[i] = 4'($urandom);
          pend[i] = 1'b1;
        end
      if (pend == 2'b00) begin
        w = $urandom_range(0, 1);
        we_q[w] = 1'($urandom); a_q[w] = $urandom; wd_q[w] = $urandom; m_q[w] = 4'($urandom);
        pend[w] = 1'b1;
      end
      drive();
      p_req = pend;
      rdv = $urandom;
      mem_rdata = rdv;
      s = ($urandom_range(0, 7) == 0) ? T + 1 + $urandom_range(0, 2) : $urandom_range(0, 4);
      tmo = s >= T + 1;
      w = (pend == 2'b11) ? (RR ? 1 - last_m : 0) : (pend == 2'b10 ? 1 : 0);
      last_m = RR ? w : last_m;
      run(s, ki, lat, ack, rd, e, nrd, nwr, a, wd, m, st);
      n_chk++; if (ack !== 2'(1 << w)) begin n_fail++; $display("FAIL rnd%0d_ack got %b want %b", it, ack, 2'(1 << w)); end
      n_chk++; if (ki !== 1 || lat !== exp_lat(s)) begin n_fail++; $display("FAIL rnd%0d_lat got %0d/%0d want 1/%0d", it, ki, lat, exp_lat(s)); end
      n_chk++; if (e !== tmo) begin n_fail++; $display("FAIL rnd%0d_err got %b want %b", it, e, tmo); end
      n_chk++; if (a !== a_q[w] || m !== m_q[w]) begin n_fail++; $display("FAIL rnd%0d_fields got %h %b want %h %b", it, a, m, a_q[w], m_q[w]); end
      n_chk++; if (nrd !== (we_q[w] ? 0 : 1) || nwr !== (we_q[w] ? 1 : 0)) begin n_fail++; $display("FAIL rnd%0d_strobes got %0d/%0d want we=%b", it, nrd, nwr, we_q[w]); end
      n_chk++; if (we_q[w] && wd !== wd_q[w]) begin n_fail++; $display("FAIL rnd%0d_wdata got %h want %h", it, wd, wd_q[w]); end
      n_chk++; if ((!we_q[w] || tmo) && rd !== (tmo ? 32'h0 : rdv)) begin n_fail++; $display("FAIL rnd%0d_rdata got %h want %h", it, rd, tmo ? 32'h0 : rdv); end
      n_chk++; if (st !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_stable got %b want 1", it, st); end
      pend[w] = 1'b0;
      idle();
    end
    p_req = 2'b00;
  endtask

  initial begin
    test_reset();
    test_read();
    test_reset_mid();
    test_write();
    test_arb();
    test_timeout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/data_mem_arb.md
DATA_MEM_ARB -- requirements
Module: data_mem_arb

Interface
REQ-001 Parameters SHALL be: TIMEOUT_CYCLES, 16, max WAIT cycles before abort; NPORT, 2, requester count (fixed at 2).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 p_req  input  2  per-port request; bit i = port i.
REQ-005 p_we  input  2  per-port write enable; 0 = read.
REQ-006 p_addr  input  64  per-port byte address; port i at [32i+31:32i].
REQ-007 p_wdata  input  64  per-port write data, same packing.
REQ-008 p_mask  input  8  per-port sign_mask; bit3 = sign-extend, bit2 = word, bit1 = halfword, else byte.
REQ-009 p_ack  output  2  one-cycle completion pulse to the granted port.
REQ-010 rdata  output  32  read data, registered, valid while p_ack is non-zero.
REQ-011 err  output  1  pulses with p_ack when the transaction timed out.
REQ-012 mem_addr / mem_wdata / mem_mask  output  32/32/4  fields latched at grant, driven to data memory.
REQ-013 mem_read / mem_write  output  1/1  one-cycle request strobes to data memory.
REQ-014 mem_rdata  input  32  data memory read result.
REQ-015 mem_stall  input  1  data memory busy flag.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-017 IDLE: on any p_req bit, pick winner, latch its addr/wdata/mask/we, go to ISSUE; otherwise stay in IDLE.
REQ-018 ISSUE, exactly one cycle: mem_read = ~we, mem_write = we; go to WAIT. Strobes SHALL be 0 in every other state.
REQ-019 WAIT: counter starts at 0, +1 per cycle; mem_stall is ignored while counter = 0.
REQ-020 WAIT exit, normal: counter >= 1 and mem_stall = 0 -> capture mem_rdata into rdata (writes: capture too, value don't-care), go to RESP.
REQ-021 WAIT exit, timeout: counter = TIMEOUT_CYCLES with mem_stall still 1 -> rdata = 0, err armed, go to RESP.
REQ-022 RESP, one cycle: p_ack[winner] = 1, err = armed flag; then IDLE.
REQ-023 Nominal latency: req sampled at edge 0 -> ISSUE -> WAIT -> p_ack high in the cycle after edge 3.
REQ-024 Requester SHALL hold req and fields until p_ack and drop req in the ack cycle. A req still high in IDLE afterwards is a new transaction.
REQ-025 Requests arriving outside IDLE are not sampled; they wait.
REQ-026 mem_addr/mem_wdata/mem_mask SHALL stay stable from ISSUE through RESP.

Reset
REQ-027 rst SHALL force, immediately and regardless of clk: IDLE; p_ack = 0, err = 0, rdata = 0, mem_read = 0, mem_write = 0, mem_addr/wdata/mask = 0; RR pointer to port 1 (so port 0 wins first); counter = 0.
REQ-028 Reset mid-transaction SHALL abort without ack. The arbiter does not suppress a write the data memory has already accepted.

Configuration
REQ-029 Macro DATA_MEM_ARB_RR_EN defined: round-robin; a tie grants the port not granted last; the pointer updates only on grant.
REQ-030 Macro absent: fixed priority, port 0 always wins ties; no pointer register.

Structure
REQ-031 Package data_mem_arb_pkg SHALL hold the state enum, NPORT, the default TIMEOUT_CYCLES and the mask field bit positions.
REQ-032 Winner selection SHALL be a sub-module data_mem_arb_pick: inputs req[1:0] and last; output onehot grant. It is purely combinational; the pointer lives in the parent.

Verification
REQ-033 Port 0 read of 0x1004, mem_rdata = 0x12345678, stall high 1 cycle -> mem_read 1 cycle, p_ack = 2'b01 at cycle 4, rdata = 0x12345678, err = 0.
REQ-034 Port 1 write of 0xCAFEF00D to 0x1008, mask 4'b0100 -> mem_write 1 cycle, mem_wdata = 0xCAFEF00D, p_ack = 2'b10, mem_read never high.
REQ-035 Both ports requesting continuously for 4 transactions -> RR build grants 0,1,0,1; non-RR build grants 0,0,0,0.
REQ-036 mem_stall held at 1 -> p_ack and err both high exactly TIMEOUT_CYCLES+2 cycles after ISSUE, rdata = 0.
REQ-037 rst pulsed during WAIT -> all outputs 0 within the same cycle, no p_ack, next request served normally with port 0 first.
